// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult
// Sequential radix-4 Booth multiplier. One Booth digit of the unsigned
// multiplier is retired per clock; each digit selects 0, +/-B or +/-2B,
// which is shifted into place and added to a 2N+2 bit accumulator.
// Outputs (busy, done, product) are registered; busy has no combinational
// path from start.
module booth_r4_seq_mult #(
    parameter int N = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    // Number of radix-4 digits needed to cover an unsigned N-bit multiplier.
    localparam int D     = N / 2 + 1;
    localparam int ACC_W = 2 * N + 2;
    localparam int CNT_W = $clog2(D + 1);
    localparam int SCN_W = N + 3;

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    logic [N-1:0]       b_reg;
    logic [SCN_W-1:0]   scan;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;

    logic [2:0]         triplet;
    logic [N:0]         mag;
    logic               neg;
    logic [ACC_W-1:0]   pp_ext;
    logic [ACC_W-1:0]   addend;
    logic [CNT_W:0]     shamt;
    logic [ACC_W-1:0]   acc_next;

    // The scan register holds {2'b00, a, 1'b0} and shifts right by two each
    // digit, so the current triplet (x[2i+1], x[2i], x[2i-1]) is always scan[2:0].
    assign triplet = scan[2:0];

    // Booth digit decode: magnitude (0, B or 2B as N+1 bits) and sign.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (triplet)
            3'b000, 3'b111: begin
                mag = '0;
                neg = 1'b0;
            end
            3'b001, 3'b010: begin
                mag = {1'b0, b_reg};
                neg = 1'b0;
            end
            3'b011: begin
                mag = {b_reg, 1'b0};
                neg = 1'b0;
            end
            3'b100: begin
                mag = {b_reg, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {1'b0, b_reg};
                neg = 1'b1;
            end
            default: begin
                mag = '0;
                neg = 1'b0;
            end
        endcase
    end

    // Partial product: ones' complement of the magnitude for negative digits,
    // extended with the digit sign (2B can occupy bit N, so the magnitude's own
    // top bit is not a sign), plus the sign carry-in, then shifted by 2i.
    always_comb begin
        pp_ext   = {{(ACC_W - N - 1){neg}}, mag ^ {(N + 1){neg}}};
        shamt    = {cnt, 1'b0};
        addend   = (pp_ext + ACC_W'(neg)) << shamt;
        acc_next = acc + addend;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cnt     <= '0;
            acc     <= '0;
            scan    <= '0;
            b_reg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        scan  <= {2'b00, a, 1'b0};
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc  <= acc_next;
                    scan <= {2'b00, scan[SCN_W-1:2]};
                    if (cnt == LAST_DIGIT) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Publish the result; busy stays high through the done cycle
                    // and drops on the following edge unless a new start arrives.
                    product <= acc[2*N-1:0];
                    done    <= 1'b1;
                    busy    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and random checks of booth_r4_seq_mult at N=8 and N=16.
module tb_booth_r4_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] p8;

    logic        start16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] p16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(.N(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (p8)
    );

    booth_r4_seq_mult #(.N(16)) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start16),
        .a       (a16),
        .b       (b16),
        .busy    (busy16),
        .done    (done16),
        .product (p16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single N=8 operation with a one-cycle start pulse; checks exact latency.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
        a8 = av; b8 = bv; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        check("busy_after_accept", busy8, 1'b1);
        for (int k = 1; k <= 5; k++) begin        // E1..E5
            tick();
            check("no_early_done", done8, 1'b0);
        end
        tick();                                   // E6
        check("done_pulse", done8, 1'b1);
        check("busy_in_done", busy8, 1'b1);
        check("product", p8, exp);
        tick();                                   // E7
        check("done_cleared", done8, 1'b0);
        check("busy_cleared", busy8, 1'b0);
        check("product_held", p8, exp);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        int          cyc;

        rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        tick(); tick();
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_product", p8, 16'h0000);
        check("rst_busy16", busy16, 1'b0);
        rst_n = 1'b1;
        tick();

        op8(8'h00, 8'hB7, 16'h0000);
        op8(8'hFF, 8'hFF, 16'hFE01);
        op8(8'hAA, 8'h55, 16'h3872);
        op8(8'h80, 8'h80, 16'h4000);
        op8(8'h01, 8'hFF, 16'h00FF);

        // start held high through CALC and DONE, operands changed mid-run.
        a8 = 8'h5D; b8 = 8'hC3; start8 = 1'b1;
        tick();                                   // E0
        tick();                                   // E1
        check("held_no_done_e1", done8, 1'b0);
        a8 = 8'h12; b8 = 8'h34;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("held_no_done", done8, 1'b0);
        end
        tick();                                   // E6
        check("held_done", done8, 1'b1);
        check("held_product", p8, 16'h46D7);
        tick();                                   // E7: new accept
        check("held_single_done", done8, 1'b0);
        check("held_reaccept_busy", busy8, 1'b1);
        start8 = 1'b0; a8 = 8'hEE; b8 = 8'hEE;
        for (int k = 8; k <= 12; k++) begin
            tick();
            check("second_no_early_done", done8, 1'b0);
        end
        tick();                                   // E13
        check("second_done", done8, 1'b1);
        check("second_product", p8, 16'h03A8);
        tick();
        check("second_idle", busy8, 1'b0);

        // Reset in the middle of CALC.
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        tick(); tick();                           // E1, E2
        rst_n = 1'b0;
        tick();                                   // E3
        check("midrst_busy", busy8, 1'b0);
        check("midrst_done", done8, 1'b0);
        check("midrst_product", p8, 16'h0000);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("midrst_no_done", done8, 1'b0);
        end
        op8(8'h03, 8'h05, 16'h000F);

        // Reset together with start: reset wins.
        rst_n = 1'b0; start8 = 1'b1; a8 = 8'h07; b8 = 8'h09;
        tick();
        check("rst_start_busy", busy8, 1'b0);
        rst_n = 1'b1; start8 = 1'b0;
        tick();
        check("rst_start_stays_idle", busy8, 1'b0);
        tick();

        // Back-to-back random operations at N=8, start held high.
        start8 = 1'b1;
        ra = 8'($urandom); rb = 8'($urandom);
        a8 = ra; b8 = rb;
        for (int n = 0; n < 300; n++) begin
            tick();                               // accept
            a8 = 8'($urandom); b8 = 8'($urandom);
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (done8 !== 1'b1 && cyc < 20);
            check("r8_latency", 64'(cyc), 64'd6);
            check("r8_product", p8, 16'(ra) * 16'(rb));
            ra = 8'($urandom); rb = 8'($urandom);
            a8 = ra; b8 = rb;
        end
        start8 = 1'b0;
        tick(); tick();

        // Back-to-back random operations at N=16 (D=9).
        start16 = 1'b1;
        ra16 = 16'($urandom); rb16 = 16'($urandom);
        a16 = ra16; b16 = rb16;
        for (int n = 0; n < 200; n++) begin
            tick();
            a16 = 16'($urandom); b16 = 16'($urandom);
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (done16 !== 1'b1 && cyc < 30);
            check("r16_latency", 64'(cyc), 64'd10);
            check("r16_product", p16, 32'(ra16) * 32'(rb16));
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            if (n == 10) begin ra16 = 16'hFFFF; rb16 = 16'hFFFF; end
            if (n == 11) begin ra16 = 16'hAAAA; rb16 = 16'h5555; end
            a16 = ra16; b16 = rb16;
        end
        start16 = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
